// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Forwarding select generation for the EX-stage source operands, plus the
// load-use / multi-cycle stall and bubble sequencing that the FE/DE/EX
// pipeline registers obey.
//
// Optional feature macro: FWD_ZERO_REG_EN
//   defined   : register 0 is hard-wired to zero; it is never forwarded and
//               never creates a load-use hazard.
//   undefined : register 0 behaves like any other register.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   flush        synchronous pipeline flush; overrides every transition
//   de_valid     DE stage holds a valid instruction
//   de_rsrc      DE source addresses, operand i at [i*REG_W +: REG_W]
//   de_use       per-operand "source actually read" flags
//   ex_rsrc      EX source addresses, operand i at [i*REG_W +: REG_W]
//   ex_en        EX instruction writes a register
//   ex_rdst      EX destination register
//   ex_is_load   EX instruction is a load
//   ex_mc_start  multi-cycle op entering EX this cycle
//   me_en/rdst   ME-stage write enable / destination
//   wb_en/rdst   WB-stage write enable / destination
//   fwd          per-operand select 00 regfile, 01 ME, 10 WB, at [2i +: 2]
//   stall_fe/de  hold FE / DE pipeline registers
//   stall_ex     hold EX pipeline register (multi-cycle only)
//   bubble_ex    insert a NOP into EX on the next edge
//   busy         FSM not in IDLE
//
// state      | meaning
// S_IDLE     | no sequence in progress; hazards detected and first stall cycle driven here
// S_LD_STALL | remaining load-use stall cycles (stall FE/DE, bubble EX)
// S_MC_BUSY  | remaining multi-cycle occupancy (stall FE/DE/EX)

module fwd_hazard_unit #(
    parameter int REG_W    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    de_valid,
    input  logic [NSRC*REG_W-1:0]   de_rsrc,
    input  logic [NSRC-1:0]         de_use,
    input  logic [NSRC*REG_W-1:0]   ex_rsrc,
    input  logic                    ex_en,
    input  logic [REG_W-1:0]        ex_rdst,
    input  logic                    ex_is_load,
    input  logic                    ex_mc_start,
    input  logic                    me_en,
    input  logic [REG_W-1:0]        me_rdst,
    input  logic                    wb_en,
    input  logic [REG_W-1:0]        wb_rdst,
    output logic [NSRC*2-1:0]       fwd,
    output logic                    stall_fe,
    output logic                    stall_de,
    output logic                    stall_ex,
    output logic                    bubble_ex,
    output logic                    busy
);

`ifdef FWD_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    // The detection cycle in IDLE is the first stall cycle of either sequence.
    // Load-use: LOAD_LAT total, so LD_STALL holds LOAD_LAT-1 cycles.
    // Multi-cycle: MC_LAT-1 total, so MC_BUSY holds MC_LAT-2 cycles.
    // The counter exits at zero, hence the loads below.
    localparam logic [3:0] LD_LOAD = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
    localparam logic [3:0] MC_LOAD = (MC_LAT > 2)   ? 4'(MC_LAT - 3)   : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LD_STALL = 2'd1,
        S_MC_BUSY  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic [NSRC-1:0] w_hit;
    logic            w_hz;
    logic            w_mc_go;

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src
            logic [REG_W-1:0] w_ex_src;
            logic [REG_W-1:0] w_de_src;
            logic             w_ex_zero;
            logic             w_de_zero;

            assign w_ex_src  = ex_rsrc[g*REG_W +: REG_W];
            assign w_de_src  = de_rsrc[g*REG_W +: REG_W];
            assign w_ex_zero = ZERO_REG && (w_ex_src == '0);
            assign w_de_zero = ZERO_REG && (w_de_src == '0);

            // ME is the younger producer, so it wins over WB.
            assign fwd[2*g +: 2] = w_ex_zero                       ? 2'b00 :
                                   (me_en && (w_ex_src == me_rdst)) ? 2'b01 :
                                   (wb_en && (w_ex_src == wb_rdst)) ? 2'b10 :
                                                                      2'b00;

            assign w_hit[g] = de_use[g] && (w_de_src == ex_rdst) && !w_de_zero;
        end
    endgenerate

    assign w_hz    = de_valid && ex_en && ex_is_load && (|w_hit);
    assign w_mc_go = ex_mc_start && (MC_LAT > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mc_go) begin
                        if (MC_LAT > 2) begin
                            w_state_nxt = S_MC_BUSY;
                            w_cnt_nxt   = MC_LOAD;
                        end
                    end else if (w_hz) begin
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = S_LD_STALL;
                            w_cnt_nxt   = LD_LOAD;
                        end
                    end
                end
                S_LD_STALL, S_MC_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_fe  = 1'b0;
        stall_de  = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mc_go) begin
                    stall_fe = 1'b1;
                    stall_de = 1'b1;
                    stall_ex = 1'b1;
                end else if (w_hz) begin
                    stall_fe  = 1'b1;
                    stall_de  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            S_LD_STALL: begin
                stall_fe  = 1'b1;
                stall_de  = 1'b1;
                bubble_ex = 1'b1;
            end
            S_MC_BUSY: begin
                stall_fe = 1'b1;
                stall_de = 1'b1;
                stall_ex = 1'b1;
            end
            default: ;
        endcase
        // Flushed instructions must not be held.
        if (flush) begin
            stall_fe  = 1'b0;
            stall_de  = 1'b0;
            stall_ex  = 1'b0;
            bubble_ex = 1'b0;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int REG_W = 3;
    localparam int NSRC  = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  de_valid;
    logic [NSRC*REG_W-1:0] de_rsrc;
    logic [NSRC-1:0]       de_use;
    logic [NSRC*REG_W-1:0] ex_rsrc;
    logic                  ex_en;
    logic [REG_W-1:0]      ex_rdst;
    logic                  ex_is_load;
    logic                  ex_mc_start;
    logic                  me_en;
    logic [REG_W-1:0]      me_rdst;
    logic                  wb_en;
    logic [REG_W-1:0]      wb_rdst;

    logic [NSRC*2-1:0] fwd1, fwd3;
    logic s_fe1, s_de1, s_ex1, bub1, busy1;
    logic s_fe3, s_de3, s_ex3, bub3, busy3;

    // u_dut1: LOAD_LAT=1, MC_LAT=4 ; u_dut3: LOAD_LAT=3, MC_LAT=4
    fwd_hazard_unit #(.REG_W(REG_W), .NSRC(NSRC), .LOAD_LAT(1), .MC_LAT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .de_valid(de_valid),
        .de_rsrc(de_rsrc), .de_use(de_use), .ex_rsrc(ex_rsrc), .ex_en(ex_en),
        .ex_rdst(ex_rdst), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
        .me_en(me_en), .me_rdst(me_rdst), .wb_en(wb_en), .wb_rdst(wb_rdst),
        .fwd(fwd1), .stall_fe(s_fe1), .stall_de(s_de1), .stall_ex(s_ex1),
        .bubble_ex(bub1), .busy(busy1)
    );

    fwd_hazard_unit #(.REG_W(REG_W), .NSRC(NSRC), .LOAD_LAT(3), .MC_LAT(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .de_valid(de_valid),
        .de_rsrc(de_rsrc), .de_use(de_use), .ex_rsrc(ex_rsrc), .ex_en(ex_en),
        .ex_rdst(ex_rdst), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
        .me_en(me_en), .me_rdst(me_rdst), .wb_en(wb_en), .wb_rdst(wb_rdst),
        .fwd(fwd3), .stall_fe(s_fe3), .stall_de(s_de3), .stall_ex(s_ex3),
        .bubble_ex(bub3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector packing: {stall_fe, stall_de, stall_ex, bubble_ex, busy}
    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_LD0  = 5'b11010;
    localparam logic [4:0] V_LD   = 5'b11011;
    localparam logic [4:0] V_MC0  = 5'b11100;
    localparam logic [4:0] V_MC   = 5'b11101;
    localparam logic [4:0] V_BUSY = 5'b00001;

    typedef struct packed {
        logic [3:0] fwd;
        logic [4:0] v1;
        logic [4:0] v3;
    } exp_t;

    exp_t q_exp[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            chk({tag, "_fwd1"}, 32'(fwd1), 32'(e.fwd));
            chk({tag, "_fwd3"}, 32'(fwd3), 32'(e.fwd));
            chk({tag, "_ctl1"}, 32'({s_fe1, s_de1, s_ex1, bub1, busy1}), 32'(e.v1));
            chk({tag, "_ctl3"}, 32'({s_fe3, s_de3, s_ex3, bub3, busy3}), 32'(e.v3));
        end
    endtask

    // Inputs are already applied; expectation is queued, outputs sampled on the
    // falling edge, then the clock advances past the next rising edge.
    task automatic step(input string tag, input logic [3:0] f, input logic [4:0] v1,
                        input logic [4:0] v3);
        exp_t e;
        e.fwd = f; e.v1 = v1; e.v3 = v3;
        q_exp.push_back(e);
        @(negedge clk);
        compare_head(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; de_valid = 0; de_rsrc = '0; de_use = '0; ex_rsrc = '0;
        ex_en = 0; ex_rdst = '0; ex_is_load = 0; ex_mc_start = 0;
        me_en = 0; me_rdst = '0; wb_en = 0; wb_rdst = '0;
    endtask

    // Load writing r5 in EX, DE operand 0 reads r5
    task automatic set_load_hz(input logic [1:0] use_v);
        de_valid = 1; de_rsrc = {3'd0, 3'd5}; de_use = use_v;
        ex_en = 1; ex_is_load = 1; ex_rdst = 3'd5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        #12;
        q_exp.push_back('{fwd: 4'b0000, v1: V_IDLE, v3: V_IDLE});
        compare_head("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Forwarding
        ex_rsrc = {3'd3, 3'd3}; me_en = 1; me_rdst = 3'd3; wb_en = 1; wb_rdst = 3'd3;
        step("fwd_me_wins", 4'b0101, V_IDLE, V_IDLE);
        me_en = 0;
        step("fwd_wb", 4'b1010, V_IDLE, V_IDLE);
        wb_en = 0;
        step("fwd_none", 4'b0000, V_IDLE, V_IDLE);
        ex_rsrc = {3'd2, 3'd5}; me_en = 1; me_rdst = 3'd5; wb_en = 1; wb_rdst = 3'd2;
        step("fwd_mixed", 4'b1001, V_IDLE, V_IDLE);
        me_rdst = 3'd2;
        step("fwd_me_op1", 4'b0100, V_IDLE, V_IDLE);
        clear_inputs();

        // Load-use hazard; EX receives the bubble so the hazard clears after one cycle
        set_load_hz(2'b01);
        step("ld_c1", 4'b0000, V_LD0, V_LD0);
        clear_inputs();
        step("ld_c2", 4'b0000, V_IDLE, V_LD);
        step("ld_c3", 4'b0000, V_IDLE, V_LD);
        step("ld_c4", 4'b0000, V_IDLE, V_IDLE);

        // Same addresses, operand not read
        set_load_hz(2'b00);
        step("ld_nouse", 4'b0000, V_IDLE, V_IDLE);
        clear_inputs();
        step("ld_nouse_after", 4'b0000, V_IDLE, V_IDLE);

        // Multi-cycle op: 3 stall cycles, no bubble
        ex_mc_start = 1;
        step("mc_c1", 4'b0000, V_MC0, V_MC0);
        ex_mc_start = 0;
        step("mc_c2", 4'b0000, V_MC, V_MC);
        step("mc_c3", 4'b0000, V_MC, V_MC);
        step("mc_c4", 4'b0000, V_IDLE, V_IDLE);

        // Multi-cycle and hazard together: multi-cycle only; hazard held is ignored in MC_BUSY
        ex_mc_start = 1; set_load_hz(2'b01);
        step("mchz_c1", 4'b0000, V_MC0, V_MC0);
        ex_mc_start = 0;
        step("mchz_c2", 4'b0000, V_MC, V_MC);
        step("mchz_c3", 4'b0000, V_MC, V_MC);
        clear_inputs();
        step("mchz_c4", 4'b0000, V_IDLE, V_IDLE);

        // Flush in MC_BUSY: stalls drop in the flush cycle, IDLE next
        ex_mc_start = 1;
        step("fl_c1", 4'b0000, V_MC0, V_MC0);
        ex_mc_start = 0; flush = 1;
        step("fl_c2", 4'b0000, V_BUSY, V_BUSY);
        flush = 0;
        step("fl_c3", 4'b0000, V_IDLE, V_IDLE);

        // Flush together with a hazard in IDLE: nothing held, no sequence started
        set_load_hz(2'b01); flush = 1;
        step("flhz_c1", 4'b0000, V_IDLE, V_IDLE);
        clear_inputs();
        step("flhz_c2", 4'b0000, V_IDLE, V_IDLE);

        // Asynchronous reset in the middle of LD_STALL
        set_load_hz(2'b01);
        step("rst_c1", 4'b0000, V_LD0, V_LD0);
        clear_inputs();
        q_exp.push_back('{fwd: 4'b0000, v1: V_IDLE, v3: V_LD});
        #1;
        compare_head("rst_pre");
        rst_n = 0;
        #1;
        q_exp.push_back('{fwd: 4'b0000, v1: V_IDLE, v3: V_IDLE});
        compare_head("rst_mid");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step("rst_after", 4'b0000, V_IDLE, V_IDLE);

        // Register 0 handling
        ex_rsrc = {3'd0, 3'd0}; me_en = 1; me_rdst = 3'd0;
`ifdef FWD_ZERO_REG_EN
        step("r0_fwd", 4'b0000, V_IDLE, V_IDLE);
`else
        step("r0_fwd", 4'b0101, V_IDLE, V_IDLE);
`endif
        clear_inputs();
        de_valid = 1; de_rsrc = {3'd0, 3'd0}; de_use = 2'b01;
        ex_en = 1; ex_is_load = 1; ex_rdst = 3'd0;
`ifdef FWD_ZERO_REG_EN
        step("r0_ld_c1", 4'b0000, V_IDLE, V_IDLE);
        clear_inputs();
        step("r0_ld_c2", 4'b0000, V_IDLE, V_IDLE);
`else
        step("r0_ld_c1", 4'b0000, V_LD0, V_LD0);
        clear_inputs();
        step("r0_ld_c2", 4'b0000, V_IDLE, V_LD);
        step("r0_ld_c3", 4'b0000, V_IDLE, V_LD);
        step("r0_ld_c4", 4'b0000, V_IDLE, V_IDLE);
`endif

        if (q_exp.size() != 0) chk("queue_drained", 32'(q_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
